inner_ebi_ctrl: RTL and testbench
=================================

// Module: inner_ebi_ctrl
// PURPOSE
//  Sequencer and arbiter for the inner EBI transceiver, the half-duplex 16-bit link to the L2/host side.
//  Shares the link between three local requesters (read miss, writeback, snoop response) and incoming packets.
//  Drives the transceiver controls: opcode, counter reload/enable, receive capture and send mode.
//  Dispatches received packets (read response, ack, snoop request) back to the cache.
//  Tracks the single outstanding host request and its timeout.
// PARAMETERS
//  EBI_WIDTH        16    link word width
//  SEND_BUF_LEN     608   width of each send packet buffer, in the transceiver's send layout
//  TIMEOUT_CYCLES   1023  cycles allowed between request send-done and its response header
//  TO_W             10    timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk              in   1             clock; all logic on posedge
//  rstn             in   1             async active-low reset
//  rd_req_valid     in   1             read miss pending; buffer rd_pkt valid
//  rd_pkt           in   SEND_BUF_LEN  packet for opcode 0 (DR)
//  wb_req_valid     in   1             writeback pending
//  wb_with_data     in   1             1: opcode 1 (DW1); 0: opcode 2 (DW2)
//  wb_pkt           in   SEND_BUF_LEN  writeback packet
//  sr_req_valid     in   1             snoop response pending
//  sr_with_data     in   1             1: opcode 3 (SNP_RESP1); 0: opcode 4 (SNP_RESP2)
//  sr_pkt           in   SEND_BUF_LEN  snoop response packet
//  rd_req_ready     out  1             1-cycle pop pulse: DR fully sent
//  wb_req_ready     out  1             1-cycle pop pulse: DW1/DW2 fully sent
//  sr_req_ready     out  1             1-cycle pop pulse: snoop response fully sent
//  rd_resp_valid    out  1             1-cycle pulse: read response in transceiver rcv buffer
//  wr_ack_valid     out  1             1-cycle pulse: write ack received
//  snp_req_valid    out  1             1-cycle pulse: snoop request in rcv buffer
//  err_timeout      out  1             1-cycle pulse: outstanding request expired
//  err_bad_opcode   out  1             1-cycle pulse: received header opcode not in {6,7,F}
//  rcv_word         in   EBI_WIDTH     transceiver's registered receive word
//  trx_rcv_start    in   1             start bit detected on idle link
//  trx_send_done    in   1             last send word issued
//  trx_rcv_done     in   1             one receive word left
//  opcode           out  4             transceiver opcode
//  send_data        out  SEND_BUF_LEN  selected packet buffer
//  is_counter_reload out 1             transceiver counter reload
//  is_counter_ena   out  1             transceiver counter enable
//  is_rd_rcv        out  1             receive-buffer capture enable
//  is_send_mode     out  1             send mode
// BEHAVIOUR
//  Reset: state IDLE, outstanding=0, timeout counter=0, all 1-bit outputs 0.
//   opcode=4'd5 (host_IDLE); send_data=0.
//  States: IDLE, S_LOAD, S_SEND, R_HDR, R_BODY, R_DONE.
//  IDLE:
//   - trx_rcv_start=1 -> R_HDR; receive beats all pending sends.
//   - Otherwise grant in fixed priority: sr > {wb, rd} -> S_LOAD.
//   - wb vs rd: round-robin toggle, updated on each wb/rd grant; reset favours rd.
//   - wb and rd are blocked while outstanding=1; sr is never blocked.
//  S_LOAD (1 cycle): is_counter_reload=1 -> S_SEND.
//   - opcode and send_data are latched from the grantee and held until return to IDLE.
//  S_SEND: is_send_mode=1, is_counter_ena=1.
//   - On trx_send_done: pop pulse to grantee -> IDLE.
//   - DR/DW grantee also sets outstanding=1, records its kind and clears the timeout counter.
//  R_HDR (1 cycle): is_counter_reload=1; latch rcv_op=rcv_word[3:0].
//   - Opcode F -> R_DONE.
//   - Opcode 6 or 7 -> R_BODY.
//   - Other -> err_bad_opcode pulse -> IDLE.
//  R_BODY: is_counter_ena=1, is_rd_rcv=1; on trx_rcv_done -> R_DONE.
//   - is_rd_rcv stays high in the done cycle.
//  R_DONE (1 cycle) -> IDLE, dispatching on rcv_op:
//   - 7: rd_resp_valid pulse.
//   - F: wr_ack_valid pulse.
//   - 6: snp_req_valid pulse.
//   - Mismatch rules for 7 and F: 7 with no outstanding DR, or F with no outstanding DW,
//     gives err_bad_opcode instead; outstanding is untouched.
//   - A matching 7/F clears outstanding.
//  Timeout counter:
//   - Increments each cycle while outstanding=1 and the state is not R_*; saturates.
//   - On reaching TIMEOUT_CYCLES: err_timeout pulse, outstanding=0, counter=0.
//  Snoop requests are accepted while a DR/DW is outstanding; the snoop response may be sent before the ack.
//  Requests arriving mid-transaction wait for IDLE; one idle cycle separates packets.
//  Async reset mid-packet aborts to IDLE and drops the outstanding request; requesters re-issue.
// STRUCTURE
//  Shared package ebi_pkg:
//   - opcode constants host_DR..slave_ACK.
//   - state enum.
//   - TIMEOUT_CYCLES default.
//  Sub-module ebi_rr_arb: 2-way round-robin for wb/rd, with a block input.
//  Send mux and FSM stay in this module.
// TESTING
//  - rd_req_valid, link idle -> S_LOAD then S_SEND, opcode=0; rd_req_ready pulses on trx_send_done; outstanding=1.
//  - DR outstanding; header rcv_word=16'h0007 after trx_rcv_start.
//    -> R_BODY until trx_rcv_done, then rd_resp_valid for 1 cycle; outstanding=0.
//  - sr, wb and rd valid together -> order sr(3), then rd(0); wb is blocked until its ack.
//    After the rd response, wb(1/2) is sent.
//  - trx_rcv_start and wb_req_valid in the same IDLE cycle -> receive first.
//    Header 16'h0006 gives snp_req_valid; the wb is sent afterwards.
//  - DW sent, no response -> err_timeout at cycle TIMEOUT_CYCLES after send-done; outstanding=0.
//    A late header F then gives err_bad_opcode.
//  - rstn low during S_SEND -> all outputs 0 and opcode=5 immediately; IDLE after rstn rises.

Source files
------------

// File: rtl/ebi_pkg.sv
// Shared definitions for the inner EBI link controller: opcodes, FSM states and
// default link/timeout parameters.
package ebi_pkg;

    localparam int unsigned EBI_WIDTH_DEF      = 16;
    localparam int unsigned SEND_BUF_LEN_DEF   = 608;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1023;
    localparam int unsigned TO_W_DEF           = 10;

    // Link opcodes: host_* are sent by us, slave_* arrive from the host side
    localparam logic [3:0] host_DR        = 4'd0;
    localparam logic [3:0] host_DW1       = 4'd1;
    localparam logic [3:0] host_DW2       = 4'd2;
    localparam logic [3:0] host_SNP_RESP1 = 4'd3;
    localparam logic [3:0] host_SNP_RESP2 = 4'd4;
    localparam logic [3:0] host_IDLE      = 4'd5;
    localparam logic [3:0] slave_SNP_REQ  = 4'd6;
    localparam logic [3:0] slave_RD_RESP  = 4'd7;
    localparam logic [3:0] slave_ACK      = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        S_LOAD,
        S_SEND,
        R_HDR,
        R_BODY,
        R_DONE
    } ebi_state_e;

    typedef enum logic [1:0] {
        GNT_RD,
        GNT_WB,
        GNT_SR
    } ebi_gnt_e;

endpackage

// File: rtl/ebi_rr_arb.sv
// Two-way round-robin arbiter between writeback and read-miss requests,
// with a block input that suppresses both grants.
module ebi_rr_arb
    import ebi_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic rd_req,
    input  logic wb_req,
    input  logic block,
    input  logic advance,
    output logic gnt_rd_c,
    output logic gnt_wb_c
);

    logic pref_wb;

    always_comb begin
        gnt_rd_c = 1'b0;
        gnt_wb_c = 1'b0;
        if (!block) begin
            if (rd_req && (!wb_req || !pref_wb)) begin
                gnt_rd_c = 1'b1;
            end else if (wb_req) begin
                gnt_wb_c = 1'b1;
            end
        end
    end

    // After serving rd favour wb, and vice versa
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pref_wb <= 1'b0;
        end else if (advance) begin
            pref_wb <= gnt_rd_c;
        end
    end

endmodule

// File: rtl/inner_ebi_ctrl.sv
// Sequencer/arbiter for the inner EBI transceiver: grants local send requests,
// steers received packets back to the cache and tracks the outstanding request.
module inner_ebi_ctrl
    import ebi_pkg::*;
#(
    parameter int unsigned EBI_WIDTH      = EBI_WIDTH_DEF,
    parameter int unsigned SEND_BUF_LEN   = SEND_BUF_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned TO_W           = TO_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    rd_req_valid,
    input  logic [SEND_BUF_LEN-1:0] rd_pkt,
    input  logic                    wb_req_valid,
    input  logic                    wb_with_data,
    input  logic [SEND_BUF_LEN-1:0] wb_pkt,
    input  logic                    sr_req_valid,
    input  logic                    sr_with_data,
    input  logic [SEND_BUF_LEN-1:0] sr_pkt,
    output logic                    rd_req_ready,
    output logic                    wb_req_ready,
    output logic                    sr_req_ready,
    output logic                    rd_resp_valid,
    output logic                    wr_ack_valid,
    output logic                    snp_req_valid,
    output logic                    err_timeout,
    output logic                    err_bad_opcode,
    input  logic [EBI_WIDTH-1:0]    rcv_word,
    input  logic                    trx_rcv_start,
    input  logic                    trx_send_done,
    input  logic                    trx_rcv_done,
    output logic [3:0]              opcode,
    output logic [SEND_BUF_LEN-1:0] send_data,
    output logic                    is_counter_reload,
    output logic                    is_counter_ena,
    output logic                    is_rd_rcv,
    output logic                    is_send_mode
);

    ebi_state_e state_q, state_d;
    ebi_gnt_e   gnt_q, gnt_d;

    logic                    outstanding_q, out_dr_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic [3:0]              rcv_op_q;
    logic [3:0]              opcode_d;
    logic [SEND_BUF_LEN-1:0] send_data_d;
    logic reload_d, ena_d, rd_rcv_d, send_mode_d;
    logic rd_pop_d, wb_pop_d, sr_pop_d, rd_resp_d, wr_ack_d, snp_req_d, bad_op_d;
    logic set_out_d, set_out_dr_d, clr_out_d, arb_adv;
    logic rd_go, wb_go, sr_go, gnt_rd_c, gnt_wb_c;
    logic to_run, timeout_hit;
    logic rcv_word_unused;

    assign rcv_word_unused = ^rcv_word[EBI_WIDTH-1:4];

    // A requester whose pop pulse is still visible has not yet dropped its valid
    assign rd_go = rd_req_valid & ~rd_req_ready;
    assign wb_go = wb_req_valid & ~wb_req_ready;
    assign sr_go = sr_req_valid & ~sr_req_ready;

    ebi_rr_arb u_rr_arb (
        .clk      (clk),
        .rstn     (rstn),
        .rd_req   (rd_go),
        .wb_req   (wb_go),
        .block    (outstanding_q),
        .advance  (arb_adv),
        .gnt_rd_c (gnt_rd_c),
        .gnt_wb_c (gnt_wb_c)
    );

    assign to_run      = outstanding_q && (state_q != R_HDR) && (state_q != R_BODY)
                         && (state_q != R_DONE);
    assign timeout_hit = to_run && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        opcode_d     = opcode;
        send_data_d  = send_data;
        reload_d     = 1'b0;
        ena_d        = 1'b0;
        rd_rcv_d     = 1'b0;
        send_mode_d  = 1'b0;
        rd_pop_d     = 1'b0;
        wb_pop_d     = 1'b0;
        sr_pop_d     = 1'b0;
        rd_resp_d    = 1'b0;
        wr_ack_d     = 1'b0;
        snp_req_d    = 1'b0;
        bad_op_d     = 1'b0;
        set_out_d    = 1'b0;
        set_out_dr_d = 1'b0;
        clr_out_d    = 1'b0;
        arb_adv      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trx_rcv_start) begin
                    state_d = R_HDR;
                end else if (sr_go) begin
                    state_d     = S_LOAD;
                    gnt_d       = GNT_SR;
                    opcode_d    = sr_with_data ? host_SNP_RESP1 : host_SNP_RESP2;
                    send_data_d = sr_pkt;
                end else if (gnt_rd_c) begin
                    state_d     = S_LOAD;
                    gnt_d       = GNT_RD;
                    opcode_d    = host_DR;
                    send_data_d = rd_pkt;
                    arb_adv     = 1'b1;
                end else if (gnt_wb_c) begin
                    state_d     = S_LOAD;
                    gnt_d       = GNT_WB;
                    opcode_d    = wb_with_data ? host_DW1 : host_DW2;
                    send_data_d = wb_pkt;
                    arb_adv     = 1'b1;
                end
            end
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (trx_send_done) begin
                    state_d  = IDLE;
                    opcode_d = host_IDLE;
                    case (gnt_q)
                        GNT_RD: begin
                            rd_pop_d     = 1'b1;
                            set_out_d    = 1'b1;
                            set_out_dr_d = 1'b1;
                        end
                        GNT_WB: begin
                            wb_pop_d  = 1'b1;
                            set_out_d = 1'b1;
                        end
                        default: sr_pop_d = 1'b1;
                    endcase
                end
            end
            R_HDR: begin
                case (rcv_word[3:0])
                    slave_ACK:                    state_d = R_DONE;
                    slave_RD_RESP, slave_SNP_REQ: state_d = R_BODY;
                    default: begin
                        state_d  = IDLE;
                        bad_op_d = 1'b1;
                    end
                endcase
            end
            R_BODY: begin
                if (trx_rcv_done) begin
                    state_d = R_DONE;
                end
            end
            R_DONE: begin
                state_d = IDLE;
                case (rcv_op_q)
                    slave_RD_RESP: begin
                        if (outstanding_q && out_dr_q) begin
                            rd_resp_d = 1'b1;
                            clr_out_d = 1'b1;
                        end else begin
                            bad_op_d = 1'b1;
                        end
                    end
                    slave_ACK: begin
                        if (outstanding_q && !out_dr_q) begin
                            wr_ack_d  = 1'b1;
                            clr_out_d = 1'b1;
                        end else begin
                            bad_op_d = 1'b1;
                        end
                    end
                    slave_SNP_REQ: snp_req_d = 1'b1;
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
        // Transceiver controls follow the state being entered, so they line up with it
        reload_d    = (state_d == S_LOAD) || (state_d == R_HDR);
        send_mode_d = (state_d == S_SEND);
        ena_d       = (state_d == S_SEND) || (state_d == R_BODY);
        rd_rcv_d    = (state_d == R_BODY) || ((state_q == R_BODY) && (state_d == R_DONE));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_q             <= GNT_RD;
            opcode            <= host_IDLE;
            send_data         <= '0;
            is_counter_reload <= 1'b0;
            is_counter_ena    <= 1'b0;
            is_rd_rcv         <= 1'b0;
            is_send_mode      <= 1'b0;
            rd_req_ready      <= 1'b0;
            wb_req_ready      <= 1'b0;
            sr_req_ready      <= 1'b0;
            rd_resp_valid     <= 1'b0;
            wr_ack_valid      <= 1'b0;
            snp_req_valid     <= 1'b0;
            err_bad_opcode    <= 1'b0;
            err_timeout       <= 1'b0;
            rcv_op_q          <= 4'd0;
            outstanding_q     <= 1'b0;
            out_dr_q          <= 1'b0;
            to_cnt_q          <= '0;
        end else begin
            gnt_q             <= gnt_d;
            opcode            <= opcode_d;
            send_data         <= send_data_d;
            is_counter_reload <= reload_d;
            is_counter_ena    <= ena_d;
            is_rd_rcv         <= rd_rcv_d;
            is_send_mode      <= send_mode_d;
            rd_req_ready      <= rd_pop_d;
            wb_req_ready      <= wb_pop_d;
            sr_req_ready      <= sr_pop_d;
            rd_resp_valid     <= rd_resp_d;
            wr_ack_valid      <= wr_ack_d;
            snp_req_valid     <= snp_req_d;
            err_bad_opcode    <= bad_op_d;
            err_timeout       <= timeout_hit;
            if (state_q == R_HDR) begin
                rcv_op_q <= rcv_word[3:0];
            end
            // Outstanding request and its timeout counter
            if (set_out_d) begin
                outstanding_q <= 1'b1;
                out_dr_q      <= set_out_dr_d;
                to_cnt_q      <= '0;
            end else if (clr_out_d || timeout_hit) begin
                outstanding_q <= 1'b0;
                to_cnt_q      <= '0;
            end else if (to_run && (to_cnt_q != '1)) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inner_ebi_ctrl.sv
// Directed bench for inner_ebi_ctrl: sends, receives, arbitration order,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_inner_ebi_ctrl;

    localparam int unsigned SBL = ebi_pkg::SEND_BUF_LEN_DEF;

    logic           clk = 1'b0;
    logic           rstn;
    logic           rd_req_valid, wb_req_valid, wb_with_data, sr_req_valid, sr_with_data;
    logic [SBL-1:0] rd_pkt, wb_pkt, sr_pkt;
    logic           rd_req_ready, wb_req_ready, sr_req_ready;
    logic           rd_resp_valid, wr_ack_valid, snp_req_valid, err_timeout, err_bad_opcode;
    logic [15:0]    rcv_word;
    logic           trx_rcv_start, trx_send_done, trx_rcv_done;
    logic [3:0]     opcode;
    logic [SBL-1:0] send_data;
    logic           is_counter_reload, is_counter_ena, is_rd_rcv, is_send_mode;

    int n_checks = 0;
    int n_errors = 0;

    inner_ebi_ctrl dut (
        .clk               (clk),
        .rstn              (rstn),
        .rd_req_valid      (rd_req_valid),
        .rd_pkt            (rd_pkt),
        .wb_req_valid      (wb_req_valid),
        .wb_with_data      (wb_with_data),
        .wb_pkt            (wb_pkt),
        .sr_req_valid      (sr_req_valid),
        .sr_with_data      (sr_with_data),
        .sr_pkt            (sr_pkt),
        .rd_req_ready      (rd_req_ready),
        .wb_req_ready      (wb_req_ready),
        .sr_req_ready      (sr_req_ready),
        .rd_resp_valid     (rd_resp_valid),
        .wr_ack_valid      (wr_ack_valid),
        .snp_req_valid     (snp_req_valid),
        .err_timeout       (err_timeout),
        .err_bad_opcode    (err_bad_opcode),
        .rcv_word          (rcv_word),
        .trx_rcv_start     (trx_rcv_start),
        .trx_send_done     (trx_send_done),
        .trx_rcv_done      (trx_rcv_done),
        .opcode            (opcode),
        .send_data         (send_data),
        .is_counter_reload (is_counter_reload),
        .is_counter_ena    (is_counter_ena),
        .is_rd_rcv         (is_rd_rcv),
        .is_send_mode      (is_send_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn          = 1'b0;
        rd_req_valid  = 1'b0;
        wb_req_valid  = 1'b0;
        sr_req_valid  = 1'b0;
        wb_with_data  = 1'b0;
        sr_with_data  = 1'b0;
        trx_rcv_start = 1'b0;
        trx_send_done = 1'b0;
        trx_rcv_done  = 1'b0;
        rcv_word      = 16'h0;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    // Wait for the load cycle, walk through the send and finish it with send-done
    task automatic send_pkt(input string tag, input logic [3:0] exp_op,
                            input logic [SBL-1:0] exp_data, input logic [2:0] exp_pop);
        int n = 0;
        while (!is_counter_reload && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_load"}, 64'(is_counter_reload), 64'(1));
        check({tag, "_op"}, 64'(opcode), 64'(exp_op));
        check({tag, "_data"}, 64'(send_data === exp_data), 64'(1));
        tick();
        check({tag, "_send_ctl"}, 64'({is_send_mode, is_counter_ena, is_counter_reload}),
              64'(3'b110));
        tick();
        trx_send_done = 1'b1;
        tick();
        trx_send_done = 1'b0;
        check({tag, "_pop"}, 64'({sr_req_ready, wb_req_ready, rd_req_ready}), 64'(exp_pop));
        check({tag, "_after"}, 64'({is_send_mode, opcode}), 64'(5'h05));
    endtask

    // Start bit, header word, optional body; returns in the cycle carrying the dispatch pulse
    task automatic rcv_pkt(input string tag, input logic [15:0] hdr);
        trx_rcv_start = 1'b1;
        tick();
        check({tag, "_hdr_ctl"}, 64'({is_counter_reload, is_send_mode, opcode}), 64'(6'h25));
        trx_rcv_start = 1'b0;
        rcv_word      = hdr;
        tick();
        if (hdr[3:0] == 4'h6 || hdr[3:0] == 4'h7) begin
            check({tag, "_body_ctl"}, 64'({is_rd_rcv, is_counter_ena}), 64'(2'b11));
            rcv_word     = 16'h5A5A;
            trx_rcv_done = 1'b1;
            tick();
            trx_rcv_done = 1'b0;
            check({tag, "_last_word"}, 64'({is_rd_rcv, is_counter_ena}), 64'(2'b10));
            tick();
        end else if (hdr[3:0] == 4'hF) begin
            check({tag, "_no_body"}, 64'(is_rd_rcv), 64'(0));
            tick();
        end
    endtask

    initial begin
        logic busy;
        int   n;
        rd_pkt = {38{16'hA0D1}};
        wb_pkt = {38{16'hB0B2}};
        sr_pkt = {38{16'hC0C3}};

        reset_dut();
        rstn = 1'b0;
        #1;
        check("reset_bits", 64'({rd_req_ready, wb_req_ready, sr_req_ready, rd_resp_valid,
              wr_ack_valid, snp_req_valid, err_timeout, err_bad_opcode, is_counter_reload,
              is_counter_ena, is_rd_rcv, is_send_mode}), 64'(0));
        check("reset_opcode", 64'(opcode), 64'(5));
        check("reset_send_data", 64'(send_data === '0), 64'(1));
        @(negedge clk);
        rstn = 1'b1;

        // Read miss send, then its read response
        rd_req_valid = 1'b1;
        send_pkt("t1_rd", 4'd0, rd_pkt, 3'b001);
        rd_req_valid = 1'b0;
        rcv_pkt("t2_resp", 16'h0007);
        check("t2_rd_resp", 64'({rd_resp_valid, err_bad_opcode}), 64'(2'b10));
        tick();
        check("t2_rd_resp_pulse", 64'(rd_resp_valid), 64'(0));
        rcv_pkt("t2_stray", 16'h0007);
        check("t2_stray_resp", 64'({rd_resp_valid, err_bad_opcode}), 64'(2'b01));

        // sr first, then rd; wb waits for the rd response
        reset_dut();
        sr_req_valid = 1'b1;
        sr_with_data = 1'b1;
        wb_req_valid = 1'b1;
        wb_with_data = 1'b0;
        rd_req_valid = 1'b1;
        send_pkt("t3_sr", 4'd3, sr_pkt, 3'b100);
        sr_req_valid = 1'b0;
        send_pkt("t3_rd", 4'd0, rd_pkt, 3'b001);
        rd_req_valid = 1'b0;
        busy = 1'b0;
        repeat (6) begin
            tick();
            busy = busy | is_send_mode | is_counter_reload;
        end
        check("t3_wb_blocked", 64'(busy), 64'(0));
        rcv_pkt("t3_resp", 16'h0007);
        check("t3_rd_resp", 64'(rd_resp_valid), 64'(1));
        send_pkt("t3_wb", 4'd2, wb_pkt, 3'b010);
        wb_req_valid = 1'b0;

        // Receive start beats a pending writeback
        reset_dut();
        wb_req_valid = 1'b1;
        wb_with_data = 1'b1;
        rcv_pkt("t4_snp", 16'h0006);
        check("t4_snp_req", 64'({snp_req_valid, err_bad_opcode}), 64'(2'b10));
        send_pkt("t4_wb", 4'd1, wb_pkt, 3'b010);
        wb_req_valid = 1'b0;

        // Unanswered writeback times out; a late ack is then rejected
        reset_dut();
        wb_req_valid = 1'b1;
        wb_with_data = 1'b1;
        send_pkt("t5_dw", 4'd1, wb_pkt, 3'b010);
        wb_req_valid = 1'b0;
        n = 0;
        while (!err_timeout && n < 2000) begin
            tick();
            n++;
        end
        check("t5_timeout_cycle", 64'(n), 64'(1023));
        tick();
        check("t5_timeout_pulse", 64'(err_timeout), 64'(0));
        rcv_pkt("t5_late_ack", 16'h000F);
        check("t5_late_ack", 64'({wr_ack_valid, err_bad_opcode}), 64'(2'b01));
        rcv_pkt("t5_bad_op", 16'h0003);
        check("t5_bad_op", 64'(err_bad_opcode), 64'(1));

        // Asynchronous reset in the middle of a send
        reset_dut();
        rd_req_valid = 1'b1;
        tick();
        tick();
        check("t6_sending", 64'(is_send_mode), 64'(1));
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_ctl", 64'({is_send_mode, is_counter_ena, is_counter_reload, opcode}),
              64'(7'h05));
        check("t6_rst_data", 64'(send_data === '0), 64'(1));
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("t6_reissue", 64'({is_counter_reload, opcode}), 64'(5'h10));
        rd_req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
